// File: rtl/conv_par_stream.sv
// conv_par_stream: loads an X frame and an F filter into local memories, then
// streams the valid 1-D convolution y[n] = sum_k x[n+k]*f[k], PAR MACs per cycle.
// Pipeline: issue (memory read + PAR products) -> product register -> accumulate/output.
module conv_par_stream #(
   parameter int DATA_WIDTH_X = 8,
   parameter int DATA_WIDTH_F = 8,
   parameter int X_SIZE       = 128,
   parameter int F_SIZE       = 32,
   parameter int PAR          = 4,
   parameter int ACC_SIZE     = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE),
   parameter int OUT_WIDTH    = ACC_SIZE,
   parameter int RELU         = 0,
   parameter int KEEP_F       = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           s_valid_x,
   output logic                           s_ready_x,
   input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
   input  logic                           s_valid_f,
   output logic                           s_ready_f,
   input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
   output logic                           m_valid_y,
   input  logic                           m_ready_y,
   output logic signed [OUT_WIDTH-1:0]    m_data_out_y,
   output logic                           busy
);
   localparam int N_OUT = X_SIZE - F_SIZE + 1;
   localparam int XAW   = $clog2(X_SIZE);
   localparam int FAW   = $clog2(F_SIZE);
   localparam int XCW   = $clog2(X_SIZE + 1);
   localparam int FCW   = $clog2(F_SIZE + 1);
   localparam int PW    = DATA_WIDTH_X + DATA_WIDTH_F;
   localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
      {{(ACC_SIZE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_SIZE-1:0] SAT_MIN =
      {{(ACC_SIZE-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN} state_t;
   state_t state_q, state_d;

   logic signed [DATA_WIDTH_X-1:0] x_mem [X_SIZE];
   logic signed [DATA_WIDTH_F-1:0] f_mem [F_SIZE];
   logic [XCW-1:0] x_cnt_q;
   logic [FCW-1:0] f_cnt_q;
   logic           f_held_q;
   logic           x_full, f_full, x_wr, f_wr;

   // issue stage: output index and first tap of the current beat
   logic [XAW-1:0] n_q;
   logic [FAW-1:0] tap_q;
   logic           issue_done_q, issue_en, beat_last, out_last;

   // product register between issue and accumulate
   logic signed [ACC_SIZE-1:0] ps_q;
   logic                       ps_valid_q, ps_first_q, ps_last_q, ps_final_q;

   logic signed [ACC_SIZE-1:0] acc_q, acc_sum, post_val, psum;
   logic signed [ACC_SIZE-1:0] prod_ext [PAR];
   logic                       out_valid_q;
   logic signed [OUT_WIDTH-1:0] out_data_q;
   logic                       out_free, stall, out_load;

   assign x_full    = (x_cnt_q == XCW'(X_SIZE));
   assign f_full    = (f_cnt_q == FCW'(F_SIZE));
   assign s_ready_x = (state_q == ST_LOAD) && !x_full;
   assign s_ready_f = (state_q == ST_LOAD) && !f_full && !((KEEP_F != 0) && f_held_q);
   assign x_wr      = s_valid_x && s_ready_x;
   assign f_wr      = s_valid_f && s_ready_f;
   assign busy      = (state_q == ST_COMPUTE);

   // The output register is free if empty or being emptied this cycle; the last
   // beat of an output may only retire into a free register, otherwise everything holds.
   assign out_free  = !out_valid_q || m_ready_y;
   assign out_load  = ps_valid_q && ps_last_q && out_free;
   assign stall     = ps_valid_q && ps_last_q && !out_free;
   assign issue_en  = (state_q == ST_COMPUTE) && !issue_done_q && !stall;
   assign beat_last = (tap_q == FAW'(F_SIZE - PAR));
   assign out_last  = (n_q == XAW'(N_OUT - 1));

   assign m_valid_y    = out_valid_q;
   assign m_data_out_y = out_data_q;

   // PAR parallel multipliers reading taps tap_q..tap_q+PAR-1 of the current window
   for (genvar gi = 0; gi < PAR; gi++) begin : g_mac
      logic [XAW-1:0]        xa;
      logic [FAW-1:0]        fa;
      logic signed [PW-1:0]  xe, fe, prod;
      assign fa   = tap_q + FAW'(gi);
      assign xa   = n_q + XAW'(tap_q) + XAW'(gi);
      assign xe   = PW'(x_mem[xa]);
      assign fe   = PW'(f_mem[fa]);
      assign prod = xe * fe;
      assign prod_ext[gi] = ACC_SIZE'(prod);
   end

   // adder tree over the sign-extended products of one beat
   always_comb begin
      psum = '0;
      for (int i = 0; i < PAR; i++) begin
         psum = psum + prod_ext[i];
      end
   end

   // accumulate and post-process: optional ReLU first, then saturation to OUT_WIDTH
   always_comb begin
      acc_sum  = (ps_first_q ? '0 : acc_q) + ps_q;
      post_val = acc_sum;
      if ((RELU != 0) && acc_sum[ACC_SIZE-1]) begin
         post_val = '0;
      end
      if (post_val > SAT_MAX) begin
         post_val = SAT_MAX;
      end else if (post_val < SAT_MIN) begin
         post_val = SAT_MIN;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:    if (x_full && f_full) state_d = ST_COMPUTE;
         ST_COMPUTE: if (out_load && ps_final_q) state_d = ST_DRAIN;
         ST_DRAIN:   if (out_valid_q && m_ready_y) state_d = ST_LOAD;
         default:    state_d = ST_LOAD;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_LOAD;
      else       state_q <= state_d;
   end

   // write counters and filter-held flag
   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt_q  <= '0;
         f_cnt_q  <= '0;
         f_held_q <= 1'b0;
      end else begin
         if (x_wr) x_cnt_q <= x_cnt_q + XCW'(1);
         if (f_wr) f_cnt_q <= f_cnt_q + FCW'(1);
         if ((state_q == ST_LOAD) && (state_d == ST_COMPUTE) && (KEEP_F != 0)) f_held_q <= 1'b1;
         if ((state_q == ST_DRAIN) && (state_d == ST_LOAD)) begin
            x_cnt_q <= '0;
            if (KEEP_F == 0) f_cnt_q <= '0;
         end
      end
   end

   // sample memories, written at ascending addresses; contents survive reset
   always_ff @(posedge clk) begin
      if (x_wr) x_mem[x_cnt_q[XAW-1:0]] <= s_data_in_x;
      if (f_wr) f_mem[f_cnt_q[FAW-1:0]] <= s_data_in_f;
   end

   // issue stage and product register; frozen while the last beat waits for the output
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q          <= '0;
         tap_q        <= '0;
         issue_done_q <= 1'b0;
         ps_q         <= '0;
         ps_valid_q   <= 1'b0;
         ps_first_q   <= 1'b0;
         ps_last_q    <= 1'b0;
         ps_final_q   <= 1'b0;
      end else if (state_q != ST_COMPUTE) begin
         n_q          <= '0;
         tap_q        <= '0;
         issue_done_q <= 1'b0;
         ps_valid_q   <= 1'b0;
      end else if (!stall) begin
         ps_valid_q <= issue_en;
         if (issue_en) begin
            ps_q       <= psum;
            ps_first_q <= (tap_q == '0);
            ps_last_q  <= beat_last;
            ps_final_q <= beat_last && out_last;
            if (beat_last) begin
               tap_q <= '0;
               if (out_last) issue_done_q <= 1'b1;
               else          n_q <= n_q + XAW'(1);
            end else begin
               tap_q <= tap_q + FAW'(PAR);
            end
         end
      end
   end

   // accumulator and output register
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (ps_valid_q && !ps_last_q) acc_q <= acc_sum;
         if (out_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= post_val[OUT_WIDTH-1:0];
         end else if (m_ready_y) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: doc/conv_par_stream.md
CONV_PAR_STREAM -- requirements
Module: conv_par_stream

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH_X, 8, signed X sample width
- DATA_WIDTH_F, 8, signed F coefficient width
- X_SIZE, 128, X samples per frame
- F_SIZE, 32, filter taps; must be >= 2 and <= X_SIZE
- PAR, 4, MACs per cycle; must divide F_SIZE
- ACC_SIZE, DATA_WIDTH_X+DATA_WIDTH_F+$clog2(F_SIZE), internal accumulator width
- OUT_WIDTH, ACC_SIZE, output width; must be <= ACC_SIZE
- RELU, 0, 1 = clamp negative results to 0
- KEEP_F, 0, 1 = retain filter across frames
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state changes on posedge
- reset, in, 1, synchronous, active-high
- s_valid_x, in, 1, X data valid
- s_ready_x, out, 1, X memory accepting
- s_data_in_x, in, DATA_WIDTH_X, signed X sample
- s_valid_f, in, 1, F data valid
- s_ready_f, out, 1, F memory accepting
- s_data_in_f, in, DATA_WIDTH_F, signed F coefficient
- m_valid_y, out, 1, Y valid
- m_ready_y, in, 1, downstream accepting Y
- m_data_out_y, out, OUT_WIDTH, signed Y result
- busy, out, 1, high in COMPUTE state

Function
REQ-003 Transfers occur on a posedge where valid && ready; X and F are written at ascending addresses from 0.
REQ-004 s_ready_x is high in LOAD while fewer than X_SIZE samples are stored; it is low in all other states.
REQ-005 s_ready_f follows the same rule for F_SIZE coefficients, except when KEEP_F=1 and a filter is already held; then it stays low.
REQ-006 FSM states are LOAD, COMPUTE, DRAIN.
- LOAD->COMPUTE on the cycle after both memories are full.
- COMPUTE->DRAIN after the final result is loaded into the output register.
- DRAIN->LOAD on the cycle the final Y handshake completes.
REQ-007 Number of outputs is N = X_SIZE-F_SIZE+1, and y[n] = sum over k=0..F_SIZE-1 of x[n+k]*f[k], for n = 0..N-1, in ascending n.
REQ-008 Each y[n] takes B = F_SIZE/PAR beats.
- Beat b multiplies taps k = b*PAR .. b*PAR+PAR-1.
- Products are sign-extended to ACC_SIZE and accumulated.
- The accumulator clears at beat 0 of each output.
REQ-009 The output register loads at the end of beat B-1, only if it is free (m_valid_y low, or m_ready_y high that cycle).
REQ-010 If the output register is not free, the compute pipeline holds beat B-1 with no state change until it frees.
REQ-011 First m_valid_y rises exactly B+1 cycles after LOAD->COMPUTE.
REQ-012 With m_ready_y held high, outputs are produced one every B cycles.
REQ-013 Result post-processing, in order:
- If RELU=1, a negative sum becomes 0.
- If OUT_WIDTH < ACC_SIZE, the sum saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-014 m_data_out_y and m_valid_y are stable while m_valid_y && !m_ready_y.
REQ-015 On DRAIN->LOAD:
- The X write counter clears.
- The F write counter clears only if KEEP_F=0.
- s_ready_x rises on the next cycle.
REQ-016 Valid inputs on a full memory or outside LOAD are ignored: no write, memory contents unchanged.
REQ-017 Simultaneous last X write and last F write in one cycle enters COMPUTE on the next cycle, same as sequential completion.

Reset
REQ-018 While reset is high at a posedge:
- State becomes LOAD; all counters and the accumulator clear; the filter-held flag clears.
- s_ready_x = 1 and s_ready_f = 1 from the following cycle.
- m_valid_y = 0, m_data_out_y = 0, busy = 0.
REQ-019 Reset asserted mid-COMPUTE or mid-DRAIN aborts the frame with no further m_valid_y; memory contents need not be cleared.

Verification
REQ-020 Scenarios (stimulus -> required response):
- Basic: X_SIZE=8, F_SIZE=4, PAR=2, x=1..8, f=1,1,1,1, m_ready_y=1 -> Y = 10,14,18,22,26 in order; first valid 3 cycles after COMPUTE entry; spacing 2 cycles.
- Backpressure: as Basic, m_ready_y low for 5 cycles after the first valid -> y[0]=10 held stable; no output lost or duplicated; busy stalls.
- Saturation/ReLU: OUT_WIDTH=8, RELU=1, x all 127, f all 127 -> every Y = 127; with f all -127 -> every Y = 0.
- KEEP_F=1: two frames, F sent once -> s_ready_f stays low in frame 2; frame-2 Y uses the original f.
- Reset mid-frame: reset during the 3rd output of Basic -> m_valid_y = 0 next cycle; s_ready_x = s_ready_f = 1; a fresh frame then produces correct Y.
- Random PAR in {1,2,4}, F_SIZE=4, random signed data and random m_ready_y -> output matches the reference model bit-exactly.
